// File: rtl/lpc_io_cycle_ctrl.sv
// LPC I/O target for the CPLD register block: decodes I/O read/write cycles
// hitting a 2**WINDOW_BITS byte window at BASE_ADDR and bridges them to the register file.
module lpc_io_cycle_ctrl #(
  parameter logic [15:0] BASE_ADDR   = 16'h0800,
  parameter int unsigned WINDOW_BITS = 5,
  parameter int unsigned SYNC_WAIT   = 1
) (
  input  logic       PciReset,
  input  logic       LpcClock,
  input  logic       LFrame_n,
  input  logic [3:0] LadIn,
  output logic [3:0] LadOut,
  output logic       LadOe,
  output logic [7:0] AddrReg,
  input  logic [7:0] DataRd,
  output logic [7:0] DataWr,
  output logic       WrStrobe,
  output logic       RdStrobe
);

  typedef enum logic [3:0] {
    IDLE, CYC, ADDR, WDAT, HTAR, SYNC, RDAT, PTAR, SKIP
  } state_t;

  localparam logic [15:0] WIN_MASK    = (16'd1 << WINDOW_BITS) - 16'd1;
  localparam logic [2:0]  SYNC_WAIT_C = 3'(SYNC_WAIT);

  state_t      state_q, state_d;
  logic [2:0]  cnt_q, cnt_d;
  logic        is_write_q, is_write_d;
  logic [11:0] addr_q, addr_d;
  logic [7:0]  addr_reg_q, addr_reg_d;
  logic [7:0]  data_wr_q, data_wr_d;
  logic [7:0]  rdata_q, rdata_d;
  logic [15:0] addr_shift;
  logic        sync_ready;

  always_ff @(posedge LpcClock or negedge PciReset) begin
    if (!PciReset) begin
      state_q    <= IDLE;
      cnt_q      <= 3'd0;
      is_write_q <= 1'b0;
      addr_q     <= 12'h000;
      addr_reg_q <= 8'h00;
      data_wr_q  <= 8'h00;
      rdata_q    <= 8'h00;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      is_write_q <= is_write_d;
      addr_q     <= addr_d;
      addr_reg_q <= addr_reg_d;
      data_wr_q  <= data_wr_d;
      rdata_q    <= rdata_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    is_write_d = is_write_q;
    addr_d     = addr_q;
    addr_reg_d = addr_reg_q;
    data_wr_d  = data_wr_q;
    rdata_d    = rdata_q;
    LadOut     = 4'hF;
    LadOe      = 1'b0;
    WrStrobe   = 1'b0;
    RdStrobe   = 1'b0;
    addr_shift = {addr_q, LadIn};
    sync_ready = is_write_q || (cnt_q == SYNC_WAIT_C);

    // LAD drive depends only on registered state so reset releases the bus at once
    case (state_q)
      SYNC: begin
        LadOe  = 1'b1;
        LadOut = sync_ready ? 4'h0 : 4'h6;
      end
      RDAT: begin
        LadOe  = 1'b1;
        LadOut = cnt_q[0] ? rdata_q[7:4] : rdata_q[3:0];
      end
      PTAR: LadOe = (cnt_q == 3'd0);
      default: ;
    endcase

    // Any LFrame_n low restarts decode; strobes only fire on an undisturbed clock
    if (!LFrame_n) begin
      state_d = (LadIn == 4'h0) ? CYC : SKIP;
      cnt_d   = 3'd0;
    end else begin
      case (state_q)
        CYC: begin
          cnt_d = 3'd0;
          if (LadIn == 4'h0 || LadIn == 4'h2) begin
            is_write_d = LadIn[1];
            state_d    = ADDR;
          end else begin
            state_d = SKIP;
          end
        end
        ADDR: begin
          addr_d = addr_shift[11:0];
          if (cnt_q == 3'd3) begin
            cnt_d = 3'd0;
            if ((addr_shift & ~WIN_MASK) == (BASE_ADDR & ~WIN_MASK)) begin
              addr_reg_d = addr_shift[7:0] & WIN_MASK[7:0];
              state_d    = is_write_q ? WDAT : HTAR;
            end else begin
              state_d = SKIP;
            end
          end else begin
            cnt_d = cnt_q + 3'd1;
          end
        end
        WDAT: begin
          if (cnt_q == 3'd0) begin
            data_wr_d[3:0] = LadIn;
            cnt_d          = 3'd1;
          end else begin
            data_wr_d[7:4] = LadIn;
            cnt_d          = 3'd0;
            state_d        = HTAR;
          end
        end
        HTAR: begin
          if (cnt_q == 3'd1) begin
            cnt_d   = 3'd0;
            state_d = SYNC;
          end else begin
            cnt_d = cnt_q + 3'd1;
          end
        end
        SYNC: begin
          if (sync_ready) begin
            cnt_d = 3'd0;
            if (is_write_q) begin
              WrStrobe = 1'b1;
              state_d  = PTAR;
            end else begin
              RdStrobe = 1'b1;
              rdata_d  = DataRd;
              state_d  = RDAT;
            end
          end else begin
            cnt_d = cnt_q + 3'd1;
          end
        end
        RDAT: begin
          if (cnt_q == 3'd1) begin
            cnt_d   = 3'd0;
            state_d = PTAR;
          end else begin
            cnt_d = cnt_q + 3'd1;
          end
        end
        PTAR: begin
          if (cnt_q == 3'd1) begin
            cnt_d   = 3'd0;
            state_d = IDLE;
          end else begin
            cnt_d = cnt_q + 3'd1;
          end
        end
        SKIP:    state_d = IDLE;
        default: ;
      endcase
    end
  end

  assign AddrReg = addr_reg_q;
  assign DataWr  = data_wr_q;

endmodule

// File: tb/tb_lpc_io_cycle_ctrl.sv
// Directed bench for lpc_io_cycle_ctrl: acts as LPC host and as a registered
// read mux returning AddrReg ^ 8'h07 one clock after AddrReg changes.
module tb_lpc_io_cycle_ctrl;

  logic       PciReset;
  logic       LpcClock;
  logic       LFrame_n;
  logic [3:0] LadIn;
  logic [3:0] LadOut;
  logic       LadOe;
  logic [7:0] AddrReg;
  logic [7:0] DataRd;
  logic [7:0] DataWr;
  logic       WrStrobe;
  logic       RdStrobe;

  int checks = 0;
  int errors = 0;

  int          clkIdx, firstOe, oeCount, wrPulses, rdPulses, releaseErr, bothErr;
  logic [31:0] ladSeq;
  logic [3:0]  strobeLad;
  logic        strobeOe;
  int          abortWr;

  lpc_io_cycle_ctrl #(
    .BASE_ADDR  (16'h0800),
    .WINDOW_BITS(5),
    .SYNC_WAIT  (1)
  ) dut (
    .PciReset(PciReset),
    .LpcClock(LpcClock),
    .LFrame_n(LFrame_n),
    .LadIn   (LadIn),
    .LadOut  (LadOut),
    .LadOe   (LadOe),
    .AddrReg (AddrReg),
    .DataRd  (DataRd),
    .DataWr  (DataWr),
    .WrStrobe(WrStrobe),
    .RdStrobe(RdStrobe)
  );

  initial LpcClock = 1'b0;
  always #5 LpcClock = ~LpcClock;

  // Registered read mux model
  always @(posedge LpcClock) DataRd <= AddrReg ^ 8'h07;

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    if (observed !== expected) begin
      errors++;
      $display("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
    end
  endtask

  task automatic clearRec();
    clkIdx    = 0;
    firstOe   = -1;
    oeCount   = 0;
    wrPulses  = 0;
    rdPulses  = 0;
    ladSeq    = 32'h0;
    strobeLad = 4'hX;
    strobeOe  = 1'b0;
  endtask

  task automatic stepClk(input logic frame, input logic [3:0] lad);
    @(negedge LpcClock);
    LFrame_n = frame;
    LadIn    = lad;
    #1;
    if (LadOe) begin
      if (firstOe < 0) firstOe = clkIdx;
      oeCount++;
      ladSeq = {ladSeq[27:0], LadOut};
    end else if (LadOut !== 4'hF) begin
      releaseErr++;
    end
    if (WrStrobe) begin
      wrPulses++;
      strobeLad = LadOut;
      strobeOe  = LadOe;
    end
    if (RdStrobe) rdPulses++;
    if (WrStrobe && RdStrobe) bothErr++;
    clkIdx++;
  endtask

  task automatic applyStimulus(input logic isWrite, input logic [15:0] addr, input logic [7:0] data);
    clearRec();
    stepClk(1'b0, 4'h0);
    stepClk(1'b1, isWrite ? 4'h2 : 4'h0);
    for (int i = 0; i < 4; i++) stepClk(1'b1, addr[15-4*i -: 4]);
    if (isWrite) begin
      stepClk(1'b1, data[3:0]);
      stepClk(1'b1, data[7:4]);
    end
    repeat (12) stepClk(1'b1, 4'hF);
  endtask

  initial begin
    releaseErr = 0;
    bothErr    = 0;
    PciReset   = 1'b0;
    LFrame_n   = 1'b1;
    LadIn      = 4'hF;
    #12;
    checkOutput("resetState", {LadOe, LadOut, AddrReg, DataWr, WrStrobe, RdStrobe},
                {1'b0, 4'hF, 8'h00, 8'h00, 2'b00});
    @(negedge LpcClock);
    PciReset = 1'b1;
    repeat (2) stepClk(1'b1, 4'hF);

    $display("[TB] read hit 0x0804");
    applyStimulus(1'b0, 16'h0804, 8'h00);
    checkOutput("rdAddrReg", AddrReg, 8'h04);
    checkOutput("rdLadSeq", ladSeq, 32'h0006030F);
    checkOutput("rdOeCount", oeCount, 5);
    checkOutput("rdFirstOe", firstOe, 8);
    checkOutput("rdStrobes", {rdPulses[7:0], wrPulses[7:0]}, {8'd1, 8'd0});

    $display("[TB] write hit 0x080E");
    applyStimulus(1'b1, 16'h080E, 8'hAE);
    checkOutput("wrDataWr", DataWr, 8'hAE);
    checkOutput("wrAddrReg", AddrReg, 8'h0E);
    checkOutput("wrStrobes", {wrPulses[7:0], rdPulses[7:0]}, {8'd1, 8'd0});
    checkOutput("wrStrobeSync", {strobeOe, strobeLad}, {1'b1, 4'h0});
    checkOutput("wrLadSeq", ladSeq, 32'h0000000F);
    checkOutput("wrOeCount", oeCount, 2);
    checkOutput("wrFirstOe", firstOe, 10);

    $display("[TB] window misses");
    applyStimulus(1'b0, 16'h0820, 8'h00);
    checkOutput("miss820", {oeCount[7:0], wrPulses[7:0], rdPulses[7:0], AddrReg}, {8'd0, 8'd0, 8'd0, 8'h0E});
    applyStimulus(1'b0, 16'h07FF, 8'h00);
    checkOutput("miss7FF", {oeCount[7:0], wrPulses[7:0], rdPulses[7:0], AddrReg}, {8'd0, 8'd0, 8'd0, 8'h0E});
    applyStimulus(1'b0, 16'h081F, 8'h00);
    checkOutput("hit81FAddr", AddrReg, 8'h1F);
    checkOutput("hit81FLad", ladSeq, 32'h0006081F);
    checkOutput("hit81FRd", rdPulses, 1);

    $display("[TB] abort during write data");
    clearRec();
    stepClk(1'b0, 4'h0);
    stepClk(1'b1, 4'h2);
    stepClk(1'b1, 4'h0);
    stepClk(1'b1, 4'h8);
    stepClk(1'b1, 4'h0);
    stepClk(1'b1, 4'h2);
    stepClk(1'b1, 4'h5);
    stepClk(1'b0, 4'h0);
    abortWr = wrPulses;
    applyStimulus(1'b0, 16'h0800, 8'h00);
    checkOutput("abortNoWr", abortWr + wrPulses, 0);
    checkOutput("abortRdLad", ladSeq, 32'h0006070F);
    checkOutput("abortRdAddr", AddrReg, 8'h00);

    $display("[TB] memory cycle skipped");
    clearRec();
    stepClk(1'b0, 4'h0);
    stepClk(1'b1, 4'h4);
    for (int i = 0; i < 10; i++) stepClk(1'b1, 4'(i + 3));
    checkOutput("memNoDrive", {oeCount[7:0], wrPulses[7:0], rdPulses[7:0]}, 24'h0);

    $display("[TB] reset during read data");
    clearRec();
    stepClk(1'b0, 4'h0);
    stepClk(1'b1, 4'h0);
    stepClk(1'b1, 4'h0);
    stepClk(1'b1, 4'h8);
    stepClk(1'b1, 4'h0);
    stepClk(1'b1, 4'h1);
    repeat (5) stepClk(1'b1, 4'hF);
    checkOutput("rdatDriving", {LadOe, LadOut}, {1'b1, 4'h6});
    PciReset = 1'b0;
    #1;
    checkOutput("rstAsync", {LadOe, LadOut, AddrReg, DataWr, WrStrobe, RdStrobe},
                {1'b0, 4'hF, 8'h00, 8'h00, 2'b00});
    @(negedge LpcClock);
    PciReset = 1'b1;
    applyStimulus(1'b0, 16'h0801, 8'h00);
    checkOutput("postRstAddr", AddrReg, 8'h01);
    checkOutput("postRstLad", ladSeq, 32'h0006060F);
    checkOutput("postRstRd", rdPulses, 1);

    checkOutput("ladReleasedF", releaseErr, 0);
    checkOutput("strobeExclusive", bothErr, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
